muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit in the EX stage. Owns the HI/LO architectural registers.
- Executes the ALU-control codes MULT (4'b1000) and DIV (4'b1001) iteratively.
- Serves MFHI (4'b0011) and MFLO (4'b0100) reads.
- Raises a stall to the hazard unit while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (≥4, even).
- SIGNED_DEFAULT, 1, signedness used when the op_signed port is tied off (1 = signed, 0 = unsigned).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op  input  4  ALU control code: 1000 mult, 1001 div, 0011 mfhi, 0100 mflo; other codes ignored
- op_valid  input  1  op/operands valid this cycle
- op_signed  input  1  1 = signed (mult/div), 0 = unsigned (multu/divu)
- src_a  input  WIDTH  rs operand (multiplicand/dividend)
- src_b  input  WIDTH  rt operand (multiplier/divisor)
- flush  input  1  squash the in-flight operation
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: HI/LO just updated
- stall  output  1  pipeline must hold the issuing instruction
- rd_data  output  WIDTH  HI for mfhi, LO for mflo, else 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, stall=0, hi=0, lo=0, counter=0. Applies at any time, including mid-operation; the partial result is discarded.
- FSM states: IDLE, CALC, FIX.
  - IDLE→CALC on op_valid && op∈{mult,div} && !flush. Operands latched. Signed mode: absolute values taken and result/remainder signs stored. Counter=WIDTH−1.
  - CALC: one iteration per cycle.
    - mult: shift-add over 2·WIDTH-bit accumulator.
    - div: restoring shift-subtract, WIDTH-bit remainder plus 1 guard bit.
    - Counter decrements. At counter==0 → FIX.
  - FIX: apply sign correction, write HI/LO, → IDLE. done=1 in the cycle following the FIX edge.
- Latency: start accepted at edge E0. HI/LO hold the new values and done=1 after edge E0+WIDTH+1. busy=1 from after E0 until after E0+WIDTH+1.
- Result mapping:
  - mult: {hi,lo} = full 2·WIDTH product, signed or unsigned per op_signed.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero: hi=src_a, lo=all ones. Still takes full latency, no exception.
- Signed overflow (MIN / −1): lo=MIN, hi=0.
- op_valid with mult/div while busy: not accepted, stall=1. The issuer holds op/operands stable and is accepted on the first non-busy cycle, which is the cycle done=1. Back-to-back issue is therefore legal with no bubble beyond latency.
- mfhi/mflo:
  - Combinational read: rd_data=hi or lo.
  - stall=busy && op_valid && op∈{mfhi,mflo,mult,div}.
  - While stalled, rd_data reflects current (old) HI/LO. Callers must not consume it.
- flush:
  - In CALC or FIX: → IDLE next edge, HI/LO unchanged, no done pulse.
  - Flush in the same cycle as an accept: no start.
- Unsigned mode uses operands as-is with no sign fixup.

Decomposition:
- Shared package/header: ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_MFHI, ALU_MFLO, ALU_SUB, ALU_SLT, ALU_MULT, ALU_DIV, ALU_ADDI, ALU_NOR, ALU_JUMP) and the FSM state encoding. The ALU-control decoder and this block both include it.
- One natural sub-module: muldiv_datapath, holding the accumulator/remainder register, one iteration step and sign fixup. The FSM, counter, stall and HI/LO regs stay in muldiv_unit.

Test Plan:
- Reset mid-CALC: mult 7×6 issued, rst_n low at cycle 10 → busy=0, hi=lo=0; no done after release.
- Signed mult, WIDTH=32: src_a=−3 (FFFFFFFD), src_b=5, op_signed=1 → after 33 edges done=1, hi=FFFFFFFF, lo=FFFFFFF1. Unsigned mult FFFFFFFF×2 → hi=00000001, lo=FFFFFFFE.
- Signed div −7/2 → lo=FFFFFFFD, hi=FFFFFFFF. Unsigned 100/7 → lo=14, hi=2. Divide by zero 9/0 → lo=FFFFFFFF, hi=9. 80000000/FFFFFFFF signed → lo=80000000, hi=0.
- Interlock: mflo issued 3 cycles after div → stall=1 until done. Once the stall clears, rd_data=new LO. Back-to-back mult issued while busy is accepted on the done cycle.
- Flush at cycle 5 of div → busy drops next edge, hi/lo keep prior values, no done.
- WIDTH=8 instance: signed mult 0x80×0x80 → {hi,lo}=0x4000 after 9 edges. Signed div 0x81/0x03 → lo=0xD6, hi=0xFF.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit_pkg : ALU control codes and mul/div FSM state encoding   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package muldiv_unit_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MFHI = 4'b0011;
    localparam logic [3:0] ALU_MFLO = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_ADDI = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_JUMP = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } muldiv_state_t;

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_datapath : iterative shift-add / restoring-divide datapath    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic             op_signed,
    input  logic             mode_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // mult: acc = {partial product, remaining multiplier bits}
    // div : acc = {partial remainder, dividend bits / quotient bits}
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_div0;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_neg_q;
    logic               w_neg_r;

    assign w_neg_a = op_signed & src_a[WIDTH-1];
    assign w_neg_b = op_signed & src_b[WIDTH-1];
    assign w_abs_a = w_neg_a ? -src_a : src_a;
    assign w_abs_b = w_neg_b ? -src_b : src_b;

    assign w_addend = r_acc[0] ? r_opnd : {WIDTH{1'b0}};
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    // Guard bit in w_shift/w_trial: a borrow out means the trial subtract failed.
    assign w_shift  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial  = w_shift - {1'b0, r_opnd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_div    <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
        end else if (start) begin
            r_div    <= is_div;
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_div0   <= (src_b == {WIDTH{1'b0}});
            if (is_div) begin
                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                r_opnd <= w_abs_b;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                r_opnd <= w_abs_a;
            end
        end else if (step) begin
            if (r_div) begin
                if (w_trial[WIDTH])
                    r_acc <= {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                else
                    r_acc <= {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            end
        end
    end

    assign w_neg_q = mode_signed & (r_sign_a ^ r_sign_b);
    assign w_neg_r = mode_signed & r_sign_a;
    assign w_prod  = w_neg_q ? -r_acc : r_acc;
    assign w_quo   = r_acc[WIDTH-1:0];
    assign w_rem   = r_acc[2*WIDTH-1:WIDTH];

    // A zero divisor yields quotient all ones and remainder |a|; the remainder
    // sign fix restores the original dividend, only LO needs forcing.
    always_comb begin
        res_hi = w_prod[2*WIDTH-1:WIDTH];
        res_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            res_hi = w_neg_r ? -w_rem : w_rem;
            if (r_div0)
                res_lo = {WIDTH{1'b1}};
            else
                res_lo = w_neg_q ? -w_quo : w_quo;
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit : multi-cycle MULT/DIV unit owning HI/LO, with interlock |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter bit SIGNED_DEFAULT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op,
    input  logic             op_valid,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import muldiv_unit_pkg::*;

    localparam int                  c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_init = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = {{(c_cnt_w-1){1'b0}}, 1'b1};

    muldiv_state_t        r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_signed;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;
    logic                 w_is_muldiv;
    logic                 w_is_mfx;
    logic                 w_accept;
    logic                 w_step;

    assign w_is_muldiv = is_muldiv_op(op);
    assign w_is_mfx    = (op == ALU_MFHI) || (op == ALU_MFLO);
    assign w_accept    = (r_state == ST_IDLE) && op_valid && w_is_muldiv && !flush;
    assign w_step      = (r_state == ST_CALC) && !flush;

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (w_accept),
        .step       (w_step),
        .is_div     (op == ALU_DIV),
        .op_signed  (op_signed),
        .mode_signed(r_signed),
        .src_a      (src_a),
        .src_b      (src_b),
        .res_hi     (w_res_hi),
        .res_lo     (w_res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_signed <= SIGNED_DEFAULT;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_CALC;
                        r_busy   <= 1'b1;
                        r_signed <= op_signed;
                        r_cnt    <= c_cnt_init;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = r_busy && op_valid && (w_is_muldiv || w_is_mfx);

    always_comb begin
        rd_data = '0;
        if (op == ALU_MFHI)
            rd_data = r_hi;
        else if (op == ALU_MFLO)
            rd_data = r_lo;
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_unit : directed + random checks of muldiv_unit (32 and 8)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_muldiv_unit;

    import muldiv_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;

    logic [3:0]  op32, op8;
    logic        v32, v8, s32, s8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;

    logic        busy32, done32, stall32;
    logic [31:0] rd32, hi32, lo32;
    logic        busy8, done8, stall8;
    logic [7:0]  rd8, hi8, lo8;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32), .SIGNED_DEFAULT(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .op(op32), .op_valid(v32), .op_signed(s32),
        .src_a(a32), .src_b(b32), .flush(flush), .busy(busy32), .done(done32),
        .stall(stall32), .rd_data(rd32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8), .SIGNED_DEFAULT(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .op(op8), .op_valid(v8), .op_signed(s8),
        .src_a(a8), .src_b(b8), .flush(flush), .busy(busy8), .done(done8),
        .stall(stall8), .rd_data(rd8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int w);
        return (w == 32) ? done32 : done8;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 32) ? busy32 : busy8;
    endfunction
    function automatic logic [31:0] hi_of(input int w);
        return (w == 32) ? hi32 : {24'b0, hi8};
    endfunction
    function automatic logic [31:0] lo_of(input int w);
        return (w == 32) ? lo32 : {24'b0, lo8};
    endfunction

    // Reference: plain 64-bit integer arithmetic on the w-bit operands.
    function automatic void model(input int w, input bit is_div, input bit sgn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ehi, output logic [31:0] elo);
        longint unsigned mask, ua, ub, top, p, rh, rl;
        longint x, y;
        mask = (64'd1 << w) - 64'd1;
        top  = 64'd1 << (w - 1);
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        x    = sgn ? longint'((ua ^ top) - top) : longint'(ua);
        y    = sgn ? longint'((ub ^ top) - top) : longint'(ub);
        if (!is_div) begin
            p  = sgn ? longint'(x * y) : ua * ub;
            rh = (p >> w) & mask;
            rl = p & mask;
        end else if (ub == 0) begin
            rh = ua;
            rl = mask;
        end else if (sgn) begin
            rl = longint'(x / y) & mask;
            rh = longint'(x % y) & mask;
        end else begin
            rl = (ua / ub) & mask;
            rh = (ua % ub) & mask;
        end
        ehi = rh[31:0];
        elo = rl[31:0];
    endfunction

    task automatic issue(input int w, input logic [3:0] code, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (w == 32) begin
            op32 = code; v32 = 1'b1; s32 = sgn; a32 = a; b32 = b;
        end else begin
            op8 = code; v8 = 1'b1; s8 = sgn; a8 = a[7:0]; b8 = b[7:0];
        end
        @(posedge clk); #1;
        v32 = 1'b0;
        v8  = 1'b0;
    endtask

    task automatic wait_done(input int w, output int edges);
        edges = 0;
        while (done_of(w) !== 1'b1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_mdu(input int w, input logic [3:0] code, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int edges;
        issue(w, code, sgn, a, b);
        wait_done(w, edges);
        check("latency", 64'(edges), 64'(w + 1));
        check("hi", {32'b0, hi_of(w)}, {32'b0, ehi});
        check("lo", {32'b0, lo_of(w)}, {32'b0, elo});
        check("busy_at_done", {63'b0, busy_of(w)}, 64'd0);
        @(posedge clk); #1;
        check("done_one_cycle", {63'b0, done_of(w)}, 64'd0);
    endtask

    typedef struct {
        int          w;
        logic [3:0]  code;
        bit          sgn;
        logic [31:0] a, b, ehi, elo;
    } vec_t;

    vec_t        dir [9];
    int          n, dn, edges;
    logic [31:0] ra, rb, mh, ml;
    logic [3:0]  rc;
    bit          rs;

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        op32 = 4'd0; v32 = 1'b0; s32 = 1'b0; a32 = '0; b32 = '0;
        op8  = 4'd0; v8  = 1'b0; s8  = 1'b0; a8  = '0; b8  = '0;

        dir[0] = '{32, ALU_MULT, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        dir[1] = '{32, ALU_MULT, 1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        dir[2] = '{32, ALU_DIV,  1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        dir[3] = '{32, ALU_DIV,  1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
        dir[4] = '{32, ALU_DIV,  1'b1, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFF};
        dir[5] = '{32, ALU_DIV,  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        dir[6] = '{8,  ALU_MULT, 1'b1, 32'h80,       32'h80,       32'h40,       32'h00};
        dir[7] = '{8,  ALU_DIV,  1'b1, 32'h81,       32'h03,       32'hFF,       32'hD6};
        dir[8] = '{32, ALU_DIV,  1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};

        // Reset state
        #12;
        check("rst_busy",  {63'b0, busy32}, 64'd0);
        check("rst_done",  {63'b0, done32}, 64'd0);
        check("rst_stall", {63'b0, stall32}, 64'd0);
        check("rst_hi",    {32'b0, hi32}, 64'd0);
        check("rst_lo",    {32'b0, lo32}, 64'd0);
        check("rst_hilo8", {48'b0, hi8, lo8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        foreach (dir[i])
            run_mdu(dir[i].w, dir[i].code, dir[i].sgn, dir[i].a, dir[i].b, dir[i].ehi, dir[i].elo);

        // Interlock: mflo three cycles after a div
        issue(32, ALU_DIV, 1'b1, 32'hFFFFFFF9, 32'd2);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        op32 = ALU_MFLO; v32 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (done32 !== 1'b1)
                check("stall_mflo", {63'b0, stall32}, 64'd1);
        end while (done32 !== 1'b1 && n < 100);
        check("mflo_done_seen", {63'b0, done32}, 64'd1);
        check("mflo_stall_clear", {63'b0, stall32}, 64'd0);
        check("mflo_rd", {32'b0, rd32}, {32'b0, 32'hFFFFFFFD});
        op32 = ALU_MFHI; #1;
        check("mfhi_rd", {32'b0, rd32}, {32'b0, 32'hFFFFFFFF});
        op32 = ALU_ADD; #1;
        check("rd_other_op", {32'b0, rd32}, 64'd0);
        v32 = 1'b0;

        // Back-to-back: second mult held while busy, accepted on done cycle
        issue(32, ALU_MULT, 1'b1, 32'hFFFFFFFE, 32'd3);
        @(negedge clk);
        op32 = ALU_MULT; v32 = 1'b1; s32 = 1'b0; a32 = 32'd7; b32 = 32'd6;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (done32 !== 1'b1)
                check("stall_b2b", {63'b0, stall32}, 64'd1);
        end while (done32 !== 1'b1 && n < 100);
        check("b2b_first_done", {63'b0, done32}, 64'd1);
        check("b2b_first", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFFA);
        check("b2b_stall_clear", {63'b0, stall32}, 64'd0);
        @(posedge clk); #1;
        v32 = 1'b0;
        check("b2b_second_busy", {63'b0, busy32}, 64'd1);
        wait_done(32, edges);
        check("b2b_latency", 64'(edges), 64'd33);
        check("b2b_second", {hi32, lo32}, 64'd42);

        // Flush at cycle 5 of a div
        issue(32, ALU_DIV, 1'b0, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush_busy", {63'b0, busy32}, 64'd0);
        flush = 1'b0;
        dn = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) dn++;
        end
        check("flush_no_done", 64'(dn), 64'd0);
        check("flush_hilo", {hi32, lo32}, 64'd42);

        // Flush coinciding with an accept
        @(negedge clk);
        op32 = ALU_MULT; v32 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("flush_accept_busy", {63'b0, busy32}, 64'd0);
        v32 = 1'b0; flush = 1'b0;

        // Random operations against the reference model
        for (int k = 0; k < 24; k++) begin
            rc = ($urandom_range(0, 1) == 0) ? ALU_MULT : ALU_DIV;
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 5));
                2: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            model((k % 2 == 0) ? 32 : 8, rc == ALU_DIV, rs, ra, rb, mh, ml);
            run_mdu((k % 2 == 0) ? 32 : 8, rc, rs, ra, rb, mh, ml);
        end

        // Reset in the middle of a mult
        issue(32, ALU_MULT, 1'b0, 32'd7, 32'd6);
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'b0, busy32}, 64'd0);
        check("midrst_hilo", {hi32, lo32}, 64'd0);
        check("midrst_hilo8", {48'b0, hi8, lo8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) dn++;
        end
        check("midrst_no_done", 64'(dn), 64'd0);
        check("midrst_idle", {63'b0, busy32}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
